ex_mem_stage: RTL and testbench

- EX/MEM pipeline stage of the MIPS pipelined processor.
- Registers the ALU outputs (64-bit result, zero flag, overflow) together with the EX-stage control bundle.
- Owns the architectural HI/LO registers, which are written by multiply (op 0xF) and divide (op 0x10).
- Squashes signed add/sub on overflow and raises a one-cycle exception with the EPC; feeds the MEM stage.

---
 rtl/ex_mem_stage.sv | 200 ++++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with architectural HI/LO, overflow trap and EPC capture.
// Optional macro EXMEM_OVF_CNT_EN adds a saturating 16-bit overflow-exception counter (ovf_count).
`default_nettype none

module ex_mem_stage #(
    parameter int PC_W       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [63:0]           ex_result,
    input  logic                  ex_zero,
    input  logic                  ex_overflow,
    input  logic [4:0]            ex_alu_op,
    input  logic                  ex_trap_en,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_branch,
    input  logic [1:0]            ex_hilo_read,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic [63:0]           ex_store_data,
    input  logic [PC_W-1:0]       ex_pc,
    output logic                  mem_valid,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_to_reg,
    output logic                  mem_branch_taken,
    output logic                  mem_zero,
    output logic [63:0]           mem_result,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic [63:0]           mem_store_data,
    output logic [31:0]           hi_out,
    output logic [31:0]           lo_out,
    output logic                  exc_overflow,
`ifdef EXMEM_OVF_CNT_EN
    output logic [15:0]           ovf_count,
`endif
    output logic [PC_W-1:0]       exc_epc
);

    localparam logic [4:0] c_OP_ADD  = 5'h03;
    localparam logic [4:0] c_OP_SUB  = 5'h05;
    localparam logic [4:0] c_OP_MULT = 5'h0F;
    localparam logic [4:0] c_OP_DIV  = 5'h10;

    logic                  valid_q,   valid_d;
    logic                  regw_q,    regw_d;
    logic                  memr_q,    memr_d;
    logic                  memw_q,    memw_d;
    logic                  m2r_q,     m2r_d;
    logic                  brt_q,     brt_d;
    logic                  zero_q,    zero_d;
    logic [63:0]           result_q,  result_d;
    logic [REG_ADDR_W-1:0] dest_q,    dest_d;
    logic [63:0]           sdata_q,   sdata_d;
    logic [31:0]           hi_q,      hi_d;
    logic [31:0]           lo_q,      lo_d;
    logic                  exc_q,     exc_d;
    logic [PC_W-1:0]       epc_q,     epc_d;

    logic        w_trap;
    logic        w_load;
    logic [63:0] w_result;

    assign w_trap = ex_valid & ex_trap_en & ex_overflow &
                    ((ex_alu_op == c_OP_ADD) | (ex_alu_op == c_OP_SUB));
    assign w_load = ~flush & ~stall;

    // mfhi/mflo read the HI/LO value already committed, so a back-to-back mult/div is visible
    always_comb begin
        case (ex_hilo_read)
            2'b01:   w_result = {32'b0, lo_q};
            2'b10:   w_result = {32'b0, hi_q};
            default: w_result = ex_result;
        endcase
    end

    always_comb begin
        valid_d  = valid_q;
        regw_d   = regw_q;
        memr_d   = memr_q;
        memw_d   = memw_q;
        m2r_d    = m2r_q;
        brt_d    = brt_q;
        zero_d   = zero_q;
        result_d = result_q;
        dest_d   = dest_q;
        sdata_d  = sdata_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        epc_d    = epc_q;
        exc_d    = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
            regw_d  = 1'b0;
            memr_d  = 1'b0;
            memw_d  = 1'b0;
            m2r_d   = 1'b0;
            brt_d   = 1'b0;
        end else if (!stall) begin
            valid_d  = ex_valid;
            regw_d   = ex_valid & ex_reg_write & ~w_trap;
            memr_d   = ex_valid & ex_mem_read  & ~w_trap;
            memw_d   = ex_valid & ex_mem_write & ~w_trap;
            m2r_d    = ex_valid & ex_mem_to_reg;
            brt_d    = ex_valid & ex_branch & ex_zero;
            zero_d   = ex_zero;
            result_d = w_result;
            dest_d   = ex_dest;
            sdata_d  = ex_store_data;
            exc_d    = w_trap;
            if (w_trap) begin
                epc_d = ex_pc;
            end
            if (ex_valid && (ex_alu_op == c_OP_MULT || ex_alu_op == c_OP_DIV)) begin
                hi_d = ex_result[63:32];
                lo_d = ex_result[31:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            regw_q   <= 1'b0;
            memr_q   <= 1'b0;
            memw_q   <= 1'b0;
            m2r_q    <= 1'b0;
            brt_q    <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            dest_q   <= '0;
            sdata_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            exc_q    <= 1'b0;
            epc_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            regw_q   <= regw_d;
            memr_q   <= memr_d;
            memw_q   <= memw_d;
            m2r_q    <= m2r_d;
            brt_q    <= brt_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            dest_q   <= dest_d;
            sdata_q  <= sdata_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            exc_q    <= exc_d;
            epc_q    <= epc_d;
        end
    end

`ifdef EXMEM_OVF_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (w_load && w_trap && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovf_count = cnt_q;
`endif

    assign mem_valid        = valid_q;
    assign mem_reg_write    = regw_q;
    assign mem_mem_read     = memr_q;
    assign mem_mem_write    = memw_q;
    assign mem_mem_to_reg   = m2r_q;
    assign mem_branch_taken = brt_q;
    assign mem_zero         = zero_q;
    assign mem_result       = result_q;
    assign mem_dest         = dest_q;
    assign mem_store_data   = sdata_q;
    assign hi_out           = hi_q;
    assign lo_out           = lo_q;
    assign exc_overflow     = exc_q;
    assign exc_epc          = epc_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed self-checking bench for ex_mem_stage.
`default_nettype none

module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid, ex_zero, ex_overflow, ex_trap_en;
    logic [63:0] ex_result, ex_store_data;
    logic [4:0]  ex_alu_op;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic [1:0]  ex_hilo_read;
    logic [4:0]  ex_dest;
    logic [31:0] ex_pc;
    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic        mem_branch_taken, mem_zero, exc_overflow;
    logic [63:0] mem_result, mem_store_data;
    logic [4:0]  mem_dest;
    logic [31:0] hi_out, lo_out, exc_epc;
`ifdef EXMEM_OVF_CNT_EN
    logic [15:0] ovf_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.PC_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_zero(ex_zero),
        .ex_overflow(ex_overflow), .ex_alu_op(ex_alu_op), .ex_trap_en(ex_trap_en),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_hilo_read(ex_hilo_read),
        .ex_dest(ex_dest), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_branch_taken(mem_branch_taken), .mem_zero(mem_zero), .mem_result(mem_result),
        .mem_dest(mem_dest), .mem_store_data(mem_store_data), .hi_out(hi_out), .lo_out(lo_out),
        .exc_overflow(exc_overflow),
`ifdef EXMEM_OVF_CNT_EN
        .ovf_count(ovf_count),
`endif
        .exc_epc(exc_epc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ex();
        stall = 0; flush = 0; ex_valid = 0; ex_result = '0; ex_zero = 0; ex_overflow = 0;
        ex_alu_op = '0; ex_trap_en = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_mem_to_reg = 0; ex_branch = 0; ex_hilo_read = 2'b00; ex_dest = '0;
        ex_store_data = '0; ex_pc = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {59'b0, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
                              mem_mem_to_reg}, 64'd0);
        check({tag, "_brz"}, {62'b0, mem_branch_taken, mem_zero}, 64'd0);
        check({tag, "_exc"}, {63'b0, exc_overflow}, 64'd0);
        check({tag, "_res"}, mem_result, 64'd0);
        check({tag, "_sd"},  mem_store_data, 64'd0);
        check({tag, "_dst"}, {59'b0, mem_dest}, 64'd0);
        check({tag, "_hilo"}, {hi_out, lo_out}, 64'd0);
        check({tag, "_epc"}, {32'b0, exc_epc}, 64'd0);
`ifdef EXMEM_OVF_CNT_EN
        check({tag, "_cnt"}, {48'b0, ovf_count}, 64'd0);
`endif
    endtask

    initial begin
        rst = 1;
        clear_ex();
        repeat (2) step();
        check_all_zero("reset");
        rst = 0;

        // mult then mfhi / mflo
        ex_valid = 1; ex_alu_op = 5'h0F; ex_result = 64'h00000002_80000000;
        ex_dest = 5'd7; ex_store_data = 64'h1234; ex_mem_to_reg = 1;
        step();
        check("mult_hi", {32'b0, hi_out}, 64'h2);
        check("mult_lo", {32'b0, lo_out}, 64'h80000000);
        check("mult_valid", {63'b0, mem_valid}, 64'd1);
        check("mult_dest", {59'b0, mem_dest}, 64'd7);
        check("mult_sd", mem_store_data, 64'h1234);
        check("mult_m2r", {63'b0, mem_mem_to_reg}, 64'd1);
        clear_ex();
        ex_valid = 1; ex_hilo_read = 2'b10; ex_result = 64'hDEAD;
        step();
        check("mfhi", mem_result, 64'h2);
        ex_hilo_read = 2'b01;
        step();
        check("mflo", mem_result, 64'h80000000);
        ex_hilo_read = 2'b11;
        step();
        check("hilo11", mem_result, 64'hDEAD);

        // div
        clear_ex();
        ex_valid = 1; ex_alu_op = 5'h10; ex_result = {32'd1, 32'd3};
        step();
        check("div_hilo", {hi_out, lo_out}, {32'd1, 32'd3});

        // div under flush: HI/LO and data hold, control cleared
        ex_result = {32'd5, 32'd6}; flush = 1;
        step();
        check("divfl_hilo", {hi_out, lo_out}, {32'd1, 32'd3});
        check("divfl_valid", {63'b0, mem_valid}, 64'd0);
        check("divfl_res", mem_result, {32'd1, 32'd3});

        // ex_valid=0 gating
        clear_ex();
        ex_alu_op = 5'h0F; ex_result = 64'hAAAA_BBBB_CCCC_DDDD; ex_reg_write = 1;
        ex_mem_read = 1; ex_branch = 1; ex_zero = 1;
        step();
        check("inv_ctl", {60'b0, mem_valid, mem_reg_write, mem_mem_read, mem_branch_taken}, 64'd0);
        check("inv_hilo", {hi_out, lo_out}, {32'd1, 32'd3});

        // overflow trap
        clear_ex();
        ex_valid = 1; ex_alu_op = 5'h03; ex_trap_en = 1; ex_overflow = 1; ex_reg_write = 1;
        ex_mem_write = 1; ex_mem_to_reg = 1; ex_pc = 32'h400010;
        step();
        check("trap_ctl", {61'b0, mem_reg_write, mem_mem_write, mem_mem_read}, 64'd0);
        check("trap_valid", {63'b0, mem_valid}, 64'd1);
        check("trap_m2r", {63'b0, mem_mem_to_reg}, 64'd1);
        check("trap_exc", {63'b0, exc_overflow}, 64'd1);
        check("trap_epc", {32'b0, exc_epc}, 64'h400010);
        clear_ex();
        step();
        check("trap_pulse", {63'b0, exc_overflow}, 64'd0);
        check("epc_sticky", {32'b0, exc_epc}, 64'h400010);

        // same stimulus, addu (no trap)
        ex_valid = 1; ex_alu_op = 5'h03; ex_trap_en = 0; ex_overflow = 1; ex_reg_write = 1;
        ex_pc = 32'h400020;
        step();
        check("notrap_rw", {63'b0, mem_reg_write}, 64'd1);
        check("notrap_exc", {63'b0, exc_overflow}, 64'd0);
        check("notrap_epc", {32'b0, exc_epc}, 64'h400010);

        // sub trap followed by stall: pulse not stretched
        clear_ex();
        ex_valid = 1; ex_alu_op = 5'h05; ex_trap_en = 1; ex_overflow = 1; ex_pc = 32'h400030;
        step();
        check("subtrap_exc", {63'b0, exc_overflow}, 64'd1);
        stall = 1;
        step();
        check("stall_exc", {63'b0, exc_overflow}, 64'd0);
        check("stall_epc", {32'b0, exc_epc}, 64'h400030);
`ifdef EXMEM_OVF_CNT_EN
        check("ovf_cnt", {48'b0, ovf_count}, 64'd2);
`endif

        // beq taken then stall x3, then flush
        clear_ex();
        ex_valid = 1; ex_branch = 1; ex_zero = 1;
        step();
        check("beq_taken", {63'b0, mem_branch_taken}, 64'd1);
        ex_branch = 0; ex_zero = 0; ex_valid = 0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_bt", {62'b0, mem_branch_taken, mem_valid}, 64'd3);
        end
        stall = 0; flush = 1;
        step();
        check("flush_bt", {62'b0, mem_branch_taken, mem_valid}, 64'd0);

        // stall and flush together: flush wins
        clear_ex();
        ex_valid = 1; ex_branch = 1; ex_zero = 1;
        step();
        stall = 1; flush = 1;
        step();
        check("stfl_bt", {62'b0, mem_branch_taken, mem_valid}, 64'd0);

        // asynchronous reset mid-stream
        clear_ex();
        ex_valid = 1; ex_alu_op = 5'h0F; ex_result = 64'h1111_2222_3333_4444; ex_reg_write = 1;
        ex_dest = 5'd9; ex_store_data = 64'h55;
        step();
        check("pre_rst_valid", {63'b0, mem_valid}, 64'd1);
        #2 rst = 1;
        #1;
        check_all_zero("async_rst");
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
